// File: rtl/pkg_frame_seq.sv
// Shared types for the frame sequencer: top-level state encoding and the codes
// reported on err_stage when a handshake phase times out.
package pkg_frame_seq;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_REL,
    ST_EG_REQ,
    ST_EG_REL,
    ST_WR_REQ,
    ST_WR_REL,
    ST_FIN,
    ST_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_RD   = 2'd1,
    ERR_EG   = 2'd2,
    ERR_WR   = 2'd3
  } err_stage_t;

  // The edge stage is skipped entirely when the frame was started in bypass.
  function automatic state_t after_read(input logic byp);
    return byp ? ST_WR_REQ : ST_EG_REQ;
  endfunction

endpackage

// File: rtl/mod_hs_phase.sv
// One 4-phase handshake (REQ holds start until done, REL waits for done to drop)
// with a per-state timeout counter that restarts on every state change.
module mod_hs_phase #(
  parameter int TMO_W   = 24,
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_req,
  input  logic in_rel,
  input  logic done_in,
  output logic start,
  output logic advance,
  output logic timed_out
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic             active;
  logic [TMO_W-1:0] cnt;

  assign active  = in_req | in_rel;
  assign start   = in_req;
  assign advance = (in_req & done_in) | (in_rel & ~done_in);

  // cnt holds the number of cycles already spent in the current state, so the
  // phase is abandoned at the end of its TIMEOUT-th cycle; a done edge wins.
  assign timed_out = (TIMEOUT != 0) && active && !advance && (cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!active || advance || timed_out) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mod_frame_seq.sv
// Frame sequencer: BMP read -> edge detect -> BMP write, each stage driven by a
// level start/done handshake, with timeout, abort, edge bypass and status.
module mod_frame_seq
  import pkg_frame_seq::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TMO_W   = 24,
  parameter int TIMEOUT = 1000000,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  input  logic              abort,
  input  logic              bypass,
  input  logic [ADDR_W-1:0] cfg_in_addr,
  input  logic [ADDR_W-1:0] cfg_out_addr,
  output logic              bmp_input_start,
  input  logic              bmp_input_done,
  output logic [ADDR_W-1:0] bmp_input_address,
  output logic              edge_start,
  input  logic              edge_done,
  output logic [ADDR_W-1:0] edge_addr_in,
  output logic [ADDR_W-1:0] edge_addr_out,
  output logic              bmp_output_start,
  input  logic              bmp_output_done,
  output logic [ADDR_W-1:0] bmp_output_address,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_stage,
  output logic [CNT_W-1:0]  frame_cnt
);

  state_t            state;
  state_t            state_nxt;
  err_stage_t        err_q;
  logic [ADDR_W-1:0] in_addr_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              bypass_q;

  logic rd_adv, rd_tmo;
  logic eg_adv, eg_tmo;
  logic wr_adv, wr_tmo;
  logic accept;
  logic tmo_hit;
  logic frame_end;

  mod_hs_phase #(.TMO_W(TMO_W), .TIMEOUT(TIMEOUT)) u_rd (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_req    (state == ST_RD_REQ),
    .in_rel    (state == ST_RD_REL),
    .done_in   (bmp_input_done),
    .start     (bmp_input_start),
    .advance   (rd_adv),
    .timed_out (rd_tmo)
  );

  mod_hs_phase #(.TMO_W(TMO_W), .TIMEOUT(TIMEOUT)) u_eg (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_req    (state == ST_EG_REQ),
    .in_rel    (state == ST_EG_REL),
    .done_in   (edge_done),
    .start     (edge_start),
    .advance   (eg_adv),
    .timed_out (eg_tmo)
  );

  mod_hs_phase #(.TMO_W(TMO_W), .TIMEOUT(TIMEOUT)) u_wr (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_req    (state == ST_WR_REQ),
    .in_rel    (state == ST_WR_REL),
    .done_in   (bmp_output_done),
    .start     (bmp_output_start),
    .advance   (wr_adv),
    .timed_out (wr_tmo)
  );

  // Abort outranks both completion and timeout; timeout already yields to done.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (go && !abort) state_nxt = ST_RD_REQ;
      ST_RD_REQ: if (abort || rd_tmo) state_nxt = ST_DRAIN;
                 else if (rd_adv)     state_nxt = ST_RD_REL;
      ST_RD_REL: if (abort || rd_tmo) state_nxt = ST_DRAIN;
                 else if (rd_adv)     state_nxt = after_read(bypass_q);
      ST_EG_REQ: if (abort || eg_tmo) state_nxt = ST_DRAIN;
                 else if (eg_adv)     state_nxt = ST_EG_REL;
      ST_EG_REL: if (abort || eg_tmo) state_nxt = ST_DRAIN;
                 else if (eg_adv)     state_nxt = ST_WR_REQ;
      ST_WR_REQ: if (abort || wr_tmo) state_nxt = ST_DRAIN;
                 else if (wr_adv)     state_nxt = ST_WR_REL;
      ST_WR_REL: if (abort || wr_tmo) state_nxt = ST_DRAIN;
                 else if (wr_adv)     state_nxt = ST_FIN;
      ST_FIN:    state_nxt = abort ? ST_DRAIN : ST_IDLE;
      ST_DRAIN:  if (!bmp_input_done && !edge_done && !bmp_output_done) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign accept    = (state == ST_IDLE) && go && !abort;
  assign tmo_hit   = !abort && (rd_tmo || eg_tmo || wr_tmo);
  assign frame_end = (state == ST_WR_REL) && wr_adv && !abort;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      in_addr_q  <= '0;
      out_addr_q <= '0;
      bypass_q   <= 1'b0;
      error      <= 1'b0;
      err_q      <= ERR_NONE;
      frame_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        in_addr_q  <= cfg_in_addr;
        out_addr_q <= cfg_out_addr;
        bypass_q   <= bypass;
        error      <= 1'b0;
        err_q      <= ERR_NONE;
      end else if (tmo_hit) begin
        error <= 1'b1;
        err_q <= rd_tmo ? ERR_RD : (eg_tmo ? ERR_EG : ERR_WR);
      end
      if (frame_end) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign busy               = (state != ST_IDLE);
  assign done               = (state == ST_FIN);
  assign err_stage          = err_q;
  assign bmp_input_address  = in_addr_q;
  assign edge_addr_in       = in_addr_q;
  assign edge_addr_out      = out_addr_q;
  assign bmp_output_address = bypass_q ? in_addr_q : out_addr_q;

endmodule

// File: tb/tb_mod_frame_seq.sv
// Bench for mod_frame_seq: emulated stage responders, a frame-level reference
// model compared every cycle, directed scenarios plus a randomized soak.
module tb_mod_frame_seq;

  localparam int TMO = 16;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset_n, go, abort, bypass;
  logic [31:0]   cfg_in_addr, cfg_out_addr;
  logic          bmp_input_start, edge_start, bmp_output_start;
  logic          bmp_input_done, edge_done, bmp_output_done;
  logic [31:0]   bmp_input_address, edge_addr_in, edge_addr_out, bmp_output_address;
  logic          busy, done, error;
  logic [1:0]    err_stage;
  logic [CW-1:0] frame_cnt;

  logic dn [3];
  assign bmp_input_done  = dn[0];
  assign edge_done       = dn[1];
  assign bmp_output_done = dn[2];

  always #5 clk = ~clk;

  mod_frame_seq #(.ADDR_W(32), .TMO_W(24), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .abort(abort), .bypass(bypass),
    .cfg_in_addr(cfg_in_addr), .cfg_out_addr(cfg_out_addr),
    .bmp_input_start(bmp_input_start), .bmp_input_done(bmp_input_done),
    .bmp_input_address(bmp_input_address),
    .edge_start(edge_start), .edge_done(edge_done),
    .edge_addr_in(edge_addr_in), .edge_addr_out(edge_addr_out),
    .bmp_output_start(bmp_output_start), .bmp_output_done(bmp_output_done),
    .bmp_output_address(bmp_output_address),
    .busy(busy), .done(done), .error(error), .err_stage(err_stage), .frame_cnt(frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 running a stage list, 2 frame done, 3 draining.
  int          m_mode, m_pos, m_len, m_cnt, m_est, m_fcnt;
  int          m_seq [3];
  bit          m_rel, m_err, m_byp;
  logic [31:0] m_in, m_out;

  // Responders and statistics.
  int rise [3], fall [3], rc [3];
  bit hang [3];
  bit abort_at_wr, abort_auto;
  bit prev_st [3];
  int overlap, done_seen, eg_hi, ord_code, drain_cyc;
  bit ab_sampled, after_abort, wr_after_abort;

  function automatic logic dut_start(input int s);
    case (s)
      0:       return bmp_input_start;
      1:       return edge_start;
      default: return bmp_output_start;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int s;
    bit d;
    if (!reset_n) begin
      m_mode = 0; m_err = 0; m_est = 0; m_fcnt = 0; m_in = '0; m_out = '0;
      m_byp = 0; m_pos = 0; m_rel = 0; m_cnt = 0; m_len = 0;
      return;
    end
    case (m_mode)
      0: if (go && !abort) begin
        m_mode = 1; m_in = cfg_in_addr; m_out = cfg_out_addr; m_byp = bypass;
        m_err = 0; m_est = 0; m_pos = 0; m_rel = 0; m_cnt = 0;
        m_seq[0] = 0;
        if (bypass) begin m_seq[1] = 2; m_len = 2; end
        else begin m_seq[1] = 1; m_seq[2] = 2; m_len = 3; end
      end
      1: begin
        s = m_seq[m_pos];
        d = dn[s];
        if (abort) m_mode = 3;
        else if (!m_rel && d) begin m_rel = 1; m_cnt = 0; end
        else if (m_rel && !d) begin
          m_pos++; m_rel = 0; m_cnt = 0;
          if (m_pos == m_len) begin m_mode = 2; m_fcnt = (m_fcnt + 1) % (1 << CW); end
        end
        else if (m_cnt == TMO - 1) begin m_err = 1; m_est = s + 1; m_mode = 3; end
        else m_cnt++;
      end
      2: m_mode = abort ? 3 : 0;
      default: if (!dn[0] && !dn[1] && !dn[2]) m_mode = 0;
    endcase
  endtask

  task automatic compare();
    bit es [3];
    for (int s = 0; s < 3; s++) es[s] = (m_mode == 1) && !m_rel && (m_seq[m_pos] == s);
    chk("bmp_input_start", 32'(bmp_input_start), 32'(es[0]));
    chk("edge_start", 32'(edge_start), 32'(es[1]));
    chk("bmp_output_start", 32'(bmp_output_start), 32'(es[2]));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("done", 32'(done), 32'(m_mode == 2));
    chk("error", 32'(error), 32'(m_err));
    chk("err_stage", 32'(err_stage), m_est);
    chk("frame_cnt", 32'(frame_cnt), m_fcnt);
    chk("bmp_input_address", bmp_input_address, m_in);
    chk("edge_addr_in", edge_addr_in, m_in);
    chk("edge_addr_out", edge_addr_out, m_out);
    chk("bmp_output_address", bmp_output_address, m_byp ? m_in : m_out);
  endtask

  task automatic respond();
    bit st;
    if (abort_auto) begin abort = 0; abort_auto = 0; end
    for (int s = 0; s < 3; s++) begin
      st = dut_start(s);
      if (!dn[s]) begin
        if (st && !hang[s]) begin
          if (rc[s] >= rise[s]) begin
            dn[s] = 1; rc[s] = 0;
            if (s == 2 && abort_at_wr) begin abort = 1; abort_at_wr = 0; abort_auto = 1; end
          end else rc[s]++;
        end else rc[s] = 0;
      end else begin
        if (!st) begin
          if (rc[s] >= fall[s]) begin dn[s] = 0; rc[s] = 0; end
          else rc[s]++;
        end else rc[s] = 0;
      end
    end
  endtask

  task automatic stats();
    int n = 0;
    for (int s = 0; s < 3; s++) begin
      if (dut_start(s)) n++;
      if (dut_start(s) && !prev_st[s]) ord_code = ord_code * 4 + s + 1;
      prev_st[s] = dut_start(s);
    end
    if (n > 1) overlap++;
    if (done) done_seen++;
    if (edge_start) eg_hi++;
    if (ab_sampled && !after_abort) begin after_abort = 1; wr_after_abort = bmp_output_start; end
    if (after_abort && busy) drain_cyc++;
  endtask

  task automatic clr_stats();
    overlap = 0; done_seen = 0; eg_hi = 0; ord_code = 0; drain_cyc = 0;
    after_abort = 0; wr_after_abort = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    ab_sampled = abort;
    model_step();
    @(negedge clk);
    compare();
    stats();
    respond();
  endtask

  task automatic pulse_go();
    go = 1; tick(); go = 0;
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    chk("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic set_resp(input int r, input int f);
    for (int s = 0; s < 3; s++) begin rise[s] = r; fall[s] = f; hang[s] = 0; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; go = 0; abort = 0; bypass = 0;
    cfg_in_addr = '0; cfg_out_addr = '0;
    abort_at_wr = 0; abort_auto = 0;
    for (int s = 0; s < 3; s++) begin dn[s] = 0; rc[s] = 0; prev_st[s] = 0; end
    set_resp(4, 1);
    clr_stats();
    tick(); tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    reset_n = 1;
    tick();

    // Nominal frame
    clr_stats();
    bypass = 0; cfg_in_addr = 32'h0000_1000; cfg_out_addr = 32'h0000_2000;
    pulse_go();
    chk("t1_start_latency", 32'(bmp_input_start), 32'd1);
    run_until_idle(300);
    chk("t1_order", ord_code, 27);
    chk("t1_overlap", overlap, 0);
    chk("t1_done_pulses", done_seen, 1);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);

    // Bypass frame
    clr_stats();
    bypass = 1; cfg_in_addr = 32'h0; cfg_out_addr = 32'h000E_1000;
    pulse_go();
    bypass = 0;
    chk("t2_out_addr", bmp_output_address, 32'h0);
    run_until_idle(300);
    chk("t2_edge_high", eg_hi, 0);
    chk("t2_order", ord_code, 7);
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd2);

    // Edge stage never answers
    clr_stats();
    hang[1] = 1; cfg_in_addr = 32'h100; cfg_out_addr = 32'h200;
    pulse_go();
    run_until_idle(300);
    hang[1] = 0;
    chk("t3_edge_high_cycles", eg_hi, TMO);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_err_stage", 32'(err_stage), 32'd2);
    chk("t3_done_pulses", done_seen, 0);

    // Abort in the write request while write done is still high
    clr_stats();
    fall[2] = 2; abort_at_wr = 1;
    pulse_go();
    run_until_idle(300);
    fall[2] = 1; abort_at_wr = 0;
    chk("t4_wr_after_abort", 32'(wr_after_abort), 32'd0);
    chk("t4_drain_cycles", drain_cyc, 3);
    chk("t4_done_pulses", done_seen, 0);
    chk("t4_error", 32'(error), 32'd0);
    chk("t4_frame_cnt", 32'(frame_cnt), 32'd2);

    // go while busy, then go together with abort in IDLE
    clr_stats();
    pulse_go();
    tick(); tick();
    pulse_go();
    run_until_idle(300);
    chk("t5_done_pulses", done_seen, 1);
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd3);
    go = 1; abort = 1; tick(); go = 0; abort = 0;
    chk("t5_go_abort_busy", 32'(busy), 32'd0);
    tick();
    chk("t5_go_abort_cnt", 32'(frame_cnt), 32'd3);

    // Reset in the edge request, then counter wrap
    pulse_go();
    for (int n = 0; n < 100 && !edge_start; n++) tick();
    chk("t6_reach_edge", 32'(edge_start), 32'd1);
    reset_n = 0; tick();
    chk("t6_rst_edge_start", 32'(edge_start), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_in_addr", bmp_input_address, 32'd0);
    chk("t6_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    reset_n = 1; tick(); tick();
    set_resp(0, 0);
    for (int i = 1; i <= 16; i++) begin
      pulse_go();
      run_until_idle(100);
      if (i == 15) chk("t6_cnt_max", 32'(frame_cnt), 32'd15);
    end
    chk("t6_cnt_wrap", 32'(frame_cnt), 32'd0);

    // Randomized soak
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0)
        for (int s = 0; s < 3; s++) begin
          rise[s] = $urandom_range(0, 18);
          fall[s] = $urandom_range(0, 18);
          hang[s] = ($urandom_range(0, 9) == 0);
        end
      go = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 39) == 0);
      bypass = $urandom_range(0, 1) == 1;
      cfg_in_addr = $urandom;
      cfg_out_addr = $urandom;
      reset_n = ($urandom_range(0, 999) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
